// File: rtl/joypad_pkg.sv
// -----------------------------------------------------------------------------
// joypad_pkg
// Shared types and constants for the 3-button pad reader.
//   jp_state_t     : poll sequencer states
//   BTN_*          : bit positions inside the published button vector
//   PIN_*          : bit positions inside the synchronized raw pin vector
//   lo_sample_t    : what is kept from the select-low half of a poll
//   assemble_buttons / pad_present : decode a completed poll
// -----------------------------------------------------------------------------
package joypad_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HI_WAIT,
      LO_WAIT,
      UPDATE
   } jp_state_t;

   // Published vector: {start, a, c, b, right, left, down, up}
   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_B     = 4;
   localparam int BTN_C     = 5;
   localparam int BTN_A     = 6;
   localparam int BTN_START = 7;

   // Raw pin vector: {c_s, a_b, right, left, down, up}
   localparam int PIN_UP    = 0;
   localparam int PIN_DOWN  = 1;
   localparam int PIN_LEFT  = 2;
   localparam int PIN_RIGHT = 3;
   localparam int PIN_AB    = 4;
   localparam int PIN_CS    = 5;
   localparam int PIN_COUNT = 6;

   // Select-low half: start/a are already active-high, left/right are kept as
   // the electrical level because they only serve pad detection.
   typedef struct packed {
      logic start;
      logic a;
      logic left_raw;
      logic right_raw;
   } lo_sample_t;

   // A pad drives both left and right low while select is low; an empty port
   // floats high through the pull-ups.
   function automatic logic pad_present(input lo_sample_t lo);
      return !lo.left_raw && !lo.right_raw;
   endfunction

   // hi is the active-high select-high sample in pin order.
   function automatic logic [7:0] assemble_buttons(input logic [PIN_COUNT-1:0] hi,
                                                   input lo_sample_t           lo,
                                                   input logic                 present);
      logic [7:0] btn;
      btn = '0;
      if (present) begin
         btn[BTN_UP]    = hi[PIN_UP];
         btn[BTN_DOWN]  = hi[PIN_DOWN];
         btn[BTN_LEFT]  = hi[PIN_LEFT];
         btn[BTN_RIGHT] = hi[PIN_RIGHT];
         btn[BTN_B]     = hi[PIN_AB];
         btn[BTN_C]     = hi[PIN_CS];
         btn[BTN_A]     = lo.a;
         btn[BTN_START] = lo.start;
      end
      return btn;
   endfunction

endpackage

// File: rtl/input_sync.sv
// -----------------------------------------------------------------------------
// input_sync
// Two-flop synchronizer for a bundle of independent asynchronous pins.
//   inp_clock : destination clock
//   inp_data  : asynchronous inputs
//   out_data  : inputs retimed into the inp_clock domain (2-cycle latency)
// Each bit is synchronized on its own; the bundle is not coherent across bits,
// which is fine because the consumer samples only after a settle window.
// -----------------------------------------------------------------------------
module input_sync #(
   parameter int Width = 1
) (
   input  logic             inp_clock,
   input  logic [Width-1:0] inp_data,
   output logic [Width-1:0] out_data
);

   logic [Width-1:0] meta;

   // NOTE: sequential state uses non-blocking assignments so both stages
   // capture the pre-edge values and the chain stays two flops deep.
   // NOTE: no reset here; stale contents flush within two cycles and nothing
   // downstream samples them that early after reset.
   always_ff @(posedge inp_clock) begin
      meta     <= inp_data;
      out_data <= meta;
   end

endmodule

// File: rtl/joypad_reader.sv
// -----------------------------------------------------------------------------
// joypad_reader
// Polls one Mega Drive style 3-button pad through its select line and
// publishes a debounced, active-high button vector.
//   inp_clock    : system clock
//   inp_reset    : synchronous, active-high reset
//   inp_up .. inp_c_s : raw active-low pad pins (asynchronous)
//   out_sel      : pad select line (high at rest)
//   out_buttons  : {start, a, c, b, right, left, down, up}, debounced
//   out_present  : pad detected on the last completed poll
//   out_valid    : one-cycle pulse per completed poll
//   out_changed  : one-cycle pulse with out_valid when out_buttons changed
// A poll samples the pad with select high, then with select low, each after a
// settle window; a result is published only when two consecutive polls agree.
// -----------------------------------------------------------------------------
module joypad_reader
   import joypad_pkg::*;
#(
   parameter int Clock        = 50_000_000,
   parameter int PollRate     = 1000,
   parameter int SettleCycles = 100
) (
   input  logic       inp_clock,
   input  logic       inp_reset,
   input  logic       inp_up,
   input  logic       inp_down,
   input  logic       inp_left,
   input  logic       inp_right,
   input  logic       inp_a_b,
   input  logic       inp_c_s,
   output logic       out_sel,
   output logic [7:0] out_buttons,
   output logic       out_present,
   output logic       out_valid,
   output logic       out_changed
);

   localparam int PollDiv = Clock / PollRate;
   localparam int DivW    = (PollDiv > 1) ? $clog2(PollDiv) : 1;
   localparam int SetW    = $clog2(SettleCycles);

   if (SettleCycles < 4) begin : g_bad_settle
      $error("joypad_reader: SettleCycles must be at least 4");
   end
   if (PollDiv < 2 * SettleCycles + 3) begin : g_bad_div
      $error("joypad_reader: poll period too short for two settle windows");
   end

   // ---------------------------------------------------------------------------
   // Pin synchronization
   // ---------------------------------------------------------------------------
   logic [PIN_COUNT-1:0] pins_raw;
   logic [PIN_COUNT-1:0] pins;

   assign pins_raw = {inp_c_s, inp_a_b, inp_right, inp_left, inp_down, inp_up};

   input_sync #(
      .Width (PIN_COUNT)
   ) u_sync (
      .inp_clock (inp_clock),
      .inp_data  (pins_raw),
      .out_data  (pins)
   );

   // ---------------------------------------------------------------------------
   // Poll divider: free running, never stalled by the sequencer
   // ---------------------------------------------------------------------------
   logic [DivW-1:0] div_cnt;
   logic            poll_tick;

   assign poll_tick = (div_cnt == DivW'(PollDiv - 1));

   always_ff @(posedge inp_clock) begin
      if (inp_reset) begin
         div_cnt <= '0;
      end else if (poll_tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Poll sequencer
   // ---------------------------------------------------------------------------
   jp_state_t       state;
   jp_state_t       state_nxt;
   logic [SetW-1:0] settle_cnt;
   logic            settle_last;
   logic            latch_hi;
   logic            latch_lo;
   logic            do_update;
   logic            sel_nxt;

   assign settle_last = (settle_cnt == SetW'(SettleCycles - 1));

   always_ff @(posedge inp_clock) begin
      if (inp_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      latch_hi  = 1'b0;
      latch_lo  = 1'b0;
      do_update = 1'b0;
      unique case (state)
         IDLE: begin
            // Ticks that land while a poll runs are simply not seen here.
            if (poll_tick) state_nxt = HI_WAIT;
         end
         HI_WAIT: begin
            if (settle_last) begin
               latch_hi  = 1'b1;
               state_nxt = LO_WAIT;
            end
         end
         LO_WAIT: begin
            if (settle_last) begin
               latch_lo  = 1'b1;
               state_nxt = UPDATE;
            end
         end
         UPDATE: begin
            do_update = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Select is registered from the next state: it drops on the first
      // LO_WAIT cycle and returns high only after UPDATE, giving a low pulse
      // of SettleCycles + 1 cycles.
      sel_nxt = !((state_nxt == LO_WAIT) || (state_nxt == UPDATE));
   end

   // Settle counter restarts at every wait-state entry.
   always_ff @(posedge inp_clock) begin
      if (inp_reset) begin
         settle_cnt <= '0;
      end else if (((state == HI_WAIT) || (state == LO_WAIT)) && !settle_last) begin
         settle_cnt <= settle_cnt + 1'b1;
      end else begin
         settle_cnt <= '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Samples: only the last settle cycle counts
   // ---------------------------------------------------------------------------
   logic [PIN_COUNT-1:0] hi_sample;
   lo_sample_t           lo_sample;

   always_ff @(posedge inp_clock) begin
      if (latch_hi) begin
         hi_sample <= ~pins;
      end
      if (latch_lo) begin
         lo_sample.start     <= ~pins[PIN_CS];
         lo_sample.a         <= ~pins[PIN_AB];
         lo_sample.left_raw  <= pins[PIN_LEFT];
         lo_sample.right_raw <= pins[PIN_RIGHT];
      end
   end

   // ---------------------------------------------------------------------------
   // Decode, debounce and publish
   // ---------------------------------------------------------------------------
   logic       present;
   logic [7:0] candidate;
   logic [7:0] prev_cand;
   logic       stable;

   always_comb begin
      present   = pad_present(lo_sample);
      candidate = assemble_buttons(hi_sample, lo_sample, present);
      stable    = (candidate == prev_cand);
   end

   always_ff @(posedge inp_clock) begin
      if (inp_reset) begin
         out_sel     <= 1'b1;
         out_buttons <= '0;
         out_present <= 1'b0;
         out_valid   <= 1'b0;
         out_changed <= 1'b0;
         prev_cand   <= '0;
      end else begin
         out_sel     <= sel_nxt;
         out_valid   <= do_update;
         out_changed <= 1'b0;
         if (do_update) begin
            out_present <= present;
            prev_cand   <= candidate;
            if (stable) begin
               out_buttons <= candidate;
               out_changed <= (candidate != out_buttons);
            end
         end
      end
   end

endmodule

// File: tb/tb_joypad_reader.sv
// -----------------------------------------------------------------------------
// tb_joypad_reader
// Drives a behavioural 3-button pad behind the DUT select line, predicts each
// poll result from the pad state and the debounce rule, and compares the
// published results in a separate monitor.
// -----------------------------------------------------------------------------
module tb_joypad_reader;

   localparam int CLOCK    = 1000;
   localparam int POLLRATE = 10;
   localparam int SETTLE   = 4;
   localparam int POLL_DIV = CLOCK / POLLRATE;
   localparam int VALID_PH = POLL_DIV - 1 + 2 * SETTLE + 2;
   localparam int FALL_PH  = (POLL_DIV + SETTLE) % POLL_DIV;
   localparam int SEL_LOW  = SETTLE + 1;

   logic       clk = 1'b0;
   logic       inp_reset;
   logic       inp_up, inp_down, inp_left, inp_right, inp_a_b, inp_c_s;
   logic       out_sel;
   logic [7:0] out_buttons;
   logic       out_present;
   logic       out_valid;
   logic       out_changed;

   always #5 clk = ~clk;

   joypad_reader #(
      .Clock        (CLOCK),
      .PollRate     (POLLRATE),
      .SettleCycles (SETTLE)
   ) dut (
      .inp_clock   (clk),
      .inp_reset   (inp_reset),
      .inp_up      (inp_up),
      .inp_down    (inp_down),
      .inp_left    (inp_left),
      .inp_right   (inp_right),
      .inp_a_b     (inp_a_b),
      .inp_c_s     (inp_c_s),
      .out_sel     (out_sel),
      .out_buttons (out_buttons),
      .out_present (out_present),
      .out_valid   (out_valid),
      .out_changed (out_changed)
   );

   // Pad model: pressed buttons in published bit order, active-high.
   logic       pad_on;
   logic [7:0] pad_btn;

   assign inp_up    = pad_on ? ~pad_btn[0] : 1'b1;
   assign inp_down  = pad_on ? ~pad_btn[1] : 1'b1;
   assign inp_left  = pad_on ? (out_sel ? ~pad_btn[2] : 1'b0) : 1'b1;
   assign inp_right = pad_on ? (out_sel ? ~pad_btn[3] : 1'b0) : 1'b1;
   assign inp_a_b   = pad_on ? (out_sel ? ~pad_btn[4] : ~pad_btn[6]) : 1'b1;
   assign inp_c_s   = pad_on ? (out_sel ? ~pad_btn[5] : ~pad_btn[7]) : 1'b1;

   // Cycles since reset release; polls land at fixed offsets from it.
   int cyc;
   always @(posedge clk) cyc <= inp_reset ? 0 : cyc + 1;

   typedef struct {
      int         cyc;
      logic [7:0] buttons;
      logic       present;
      logic       changed;
   } exp_t;

   exp_t exp_q[$];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model state: last candidate and last published vector.
   int         poll_k;
   logic [7:0] m_prev;
   logic [7:0] m_buttons;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) step();
   endtask

   task automatic run_poll(input logic pres, input logic [7:0] btn);
      exp_t       e;
      logic [7:0] cand;
      wait_cyc(POLL_DIV * poll_k + POLL_DIV / 2);
      pad_on  = pres;
      pad_btn = btn;
      cand      = pres ? btn : 8'h00;
      e.cyc     = POLL_DIV * poll_k + VALID_PH;
      e.present = pres;
      e.buttons = (cand == m_prev) ? cand : m_buttons;
      e.changed = (e.buttons != m_buttons);
      m_prev    = cand;
      m_buttons = e.buttons;
      exp_q.push_back(e);
      poll_k++;
   endtask

   // Monitor: select pulse shape and every published poll result.
   int sel_run = 0;
   always @(negedge clk) begin
      if (inp_reset) begin
         sel_run = 0;
      end else begin
         if (!out_sel) begin
            if (sel_run == 0) check("sel_fall_phase", cyc % POLL_DIV, FALL_PH);
            sel_run++;
         end else if (sel_run > 0) begin
            check("sel_low_width", sel_run, SEL_LOW);
            sel_run = 0;
         end
         if (out_changed) check("changed_with_valid", out_valid, 1);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", out_valid, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("valid_cycle", cyc, e.cyc);
               check("buttons", out_buttons, e.buttons);
               check("present", out_present, e.present);
               check("changed", out_changed, e.changed);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       r_pres;
      logic [7:0] r_btn;
      int         nvalid;

      inp_reset = 1'b1;
      pad_on    = 1'b1;
      pad_btn   = 8'h00;
      poll_k    = 0;
      m_prev    = 8'h00;
      m_buttons = 8'h00;

      // Reset state, three reset cycles.
      @(posedge clk);
      @(negedge clk);
      check("rst_sel", out_sel, 1);
      check("rst_buttons", out_buttons, 8'h00);
      check("rst_valid", out_valid, 0);
      check("rst_present", out_present, 0);
      check("rst_changed", out_changed, 0);
      repeat (2) @(posedge clk);
      #2;
      inp_reset = 1'b0;

      // B held for two polls.
      run_poll(1'b1, 8'h10);
      run_poll(1'b1, 8'h10);
      // Start + A, three identical polls.
      run_poll(1'b1, 8'hC0);
      run_poll(1'b1, 8'hC0);
      run_poll(1'b1, 8'hC0);
      // Empty port; pressed bits must be ignored.
      run_poll(1'b0, 8'hFF);
      run_poll(1'b0, 8'hFF);
      run_poll(1'b0, 8'h00);
      // Up bounces for a single poll.
      run_poll(1'b1, 8'h00);
      run_poll(1'b1, 8'h00);
      run_poll(1'b1, 8'h01);
      run_poll(1'b1, 8'h00);
      run_poll(1'b1, 8'h00);

      // Reset in the middle of LO_WAIT: no result for that poll.
      wait_cyc(POLL_DIV * poll_k + POLL_DIV / 2);
      pad_on  = 1'b1;
      pad_btn = 8'h10;
      wait_cyc(POLL_DIV * poll_k + POLL_DIV - 1 + SETTLE + 3);
      check("abort_in_lo_wait", out_sel, 0);
      inp_reset = 1'b1;
      step();
      @(negedge clk);
      check("abort_sel_high", out_sel, 1);
      check("abort_no_valid", out_valid, 0);
      step();
      inp_reset = 1'b0;
      poll_k    = 0;
      m_prev    = 8'h00;
      m_buttons = 8'h00;
      nvalid    = 0;
      while (cyc < 20) begin
         @(negedge clk);
         if (out_valid) nvalid++;
      end
      check("abort_valid_count", nvalid, 0);

      // Random pad activity; repeats give the debounce a chance to accept.
      r_pres = 1'b1;
      r_btn  = 8'h10;
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            r_pres = ($urandom_range(0, 4) != 0);
            r_btn  = 8'($urandom);
         end
         run_poll(r_pres, r_btn);
      end

      wait_cyc(POLL_DIV * poll_k + POLL_DIV / 2);
      check("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
